// File: rtl/icache_ctrl.sv
// icache_ctrl: two-way set-associative instruction cache controller.
// The tags, valid bits and LRU bits are kept in internal registers.
// The data lives in two external single-port RAMs, one per way, each with a
// one-cycle read latency.
//
// Ports:
//   clk, rst                   clock; asynchronous active-low reset
//   cpu_req/cpu_addr/cpu_ready fetch request handshake (byte address)
//   cpu_rvalid/cpu_rdata       one-cycle instruction word return
//   inv_all/inv_ack            level invalidate request, one-cycle ack pulse
//   mem_rreq/mem_raddr/mem_rack line-fill address handshake
//   mem_rvalid/mem_rdata       line-fill beats, in word-offset order
//   ram_addr/ram_en/ram_wen/ram_wdata/ram_rdata0/1  data RAM port, one per way
module icache_ctrl #(
    parameter int INDEX_W = 8,
    parameter int OFF_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    output logic        cpu_ready,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    input  logic        inv_all,
    output logic        inv_ack,
    output logic        mem_rreq,
    output logic [31:0] mem_raddr,
    input  logic        mem_rack,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [11:0] ram_addr,
    output logic [1:0]  ram_en,
    output logic [1:0]  ram_wen,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata0,
    input  logic [31:0] ram_rdata1
);
    localparam int TAG_W = 30 - OFF_W - INDEX_W;
    localparam int SETS  = 1 << INDEX_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS, REFILL, RESP} state_t;

    state_t                       state_q, state_d;
    logic [29:0]                  addr_q;      // word address of the request in flight
    logic                         victim_q;
    logic [OFF_W-1:0]             cnt_q;
    logic [31:0]                  resp_q;
    logic [1:0][SETS-1:0]         valid_q;
    logic [SETS-1:0]              lru_q;       // way to replace next
    logic [TAG_W-1:0]             tag_mem [2][SETS];
    logic                         inv_ack_q;
    logic                         accept;

    logic [TAG_W-1:0]   q_tag;
    logic [INDEX_W-1:0] q_idx;
    logic [OFF_W-1:0]   q_off;
    logic               hit0, hit1, hit, victim_sel;
    logic               unused_bits;

    assign unused_bits = ^cpu_addr[1:0];

    assign q_tag = addr_q[29 -: TAG_W];
    assign q_idx = addr_q[OFF_W +: INDEX_W];
    assign q_off = addr_q[OFF_W-1:0];

    assign hit0 = valid_q[0][q_idx] && (tag_mem[0][q_idx] == q_tag);
    assign hit1 = valid_q[1][q_idx] && (tag_mem[1][q_idx] == q_tag);
    assign hit  = hit0 | hit1;

    // First invalid way wins (way 0 first); otherwise the LRU way.
    assign victim_sel = !valid_q[0][q_idx] ? 1'b0 :
                        !valid_q[1][q_idx] ? 1'b1 : lru_q[q_idx];

    assign inv_ack   = inv_ack_q;
    assign ram_wdata = mem_rdata;

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        cpu_ready  = 1'b0;
        cpu_rvalid = 1'b0;
        cpu_rdata  = '0;
        mem_rreq   = 1'b0;
        mem_raddr  = '0;
        ram_addr   = '0;
        ram_en     = 2'b00;
        ram_wen    = 2'b00;
        case (state_q)
            IDLE: begin
                cpu_ready = !inv_all;
                if (cpu_req && !inv_all) begin
                    accept   = 1'b1;
                    ram_addr = cpu_addr[2 +: INDEX_W + OFF_W];
                    ram_en   = 2'b11;
                    state_d  = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    cpu_rvalid = 1'b1;
                    cpu_rdata  = hit0 ? ram_rdata0 : ram_rdata1;
                    cpu_ready  = 1'b1;
                    // Back-to-back fetch: issue the next read while returning this one.
                    if (cpu_req) begin
                        accept   = 1'b1;
                        ram_addr = cpu_addr[2 +: INDEX_W + OFF_W];
                        ram_en   = 2'b11;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = MISS;
                end
            end
            MISS: begin
                mem_rreq  = 1'b1;
                mem_raddr = {addr_q[29:OFF_W], {(OFF_W + 2){1'b0}}};
                if (mem_rack) state_d = REFILL;
            end
            REFILL: begin
                if (mem_rvalid) begin
                    ram_addr = {q_idx, cnt_q};
                    ram_en   = victim_q ? 2'b10 : 2'b01;
                    ram_wen  = victim_q ? 2'b10 : 2'b01;
                    if (&cnt_q) state_d = RESP;
                end
            end
            RESP: begin
                cpu_rvalid = 1'b1;
                cpu_rdata  = resp_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            victim_q  <= 1'b0;
            cnt_q     <= '0;
            resp_q    <= '0;
            valid_q   <= '0;
            lru_q     <= '0;
            inv_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            inv_ack_q <= (state_q == IDLE) && inv_all;
            if (accept) addr_q <= cpu_addr[31:2];
            case (state_q)
                IDLE: begin
                    if (inv_all) begin
                        valid_q <= '0;
                        lru_q   <= '0;
                    end
                end
                LOOKUP: begin
                    if (hit) lru_q[q_idx] <= hit0;  // point at the other way
                    else     victim_q     <= victim_sel;
                end
                REFILL: begin
                    if (mem_rvalid) begin
                        cnt_q <= cnt_q + 1'b1;      // wraps to 0 after the last beat
                        if (cnt_q == q_off) resp_q <= mem_rdata;
                        // The line becomes valid only once every beat is written,
                        // so an abandoned refill never leaves a half-filled valid line.
                        if (&cnt_q) begin
                            valid_q[victim_q][q_idx] <= 1'b1;
                            lru_q[q_idx]             <= ~victim_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Tags need no reset: they are qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (state_q == REFILL && mem_rvalid && (&cnt_q))
            tag_mem[victim_q][q_idx] <= q_tag;
    end
endmodule

// File: tb/tb_icache_ctrl.sv
module tb_icache_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic        cpu_ready, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        inv_all, inv_ack;
    logic        mem_rreq;
    logic [31:0] mem_raddr;
    logic        mem_rack, mem_rvalid;
    logic [31:0] mem_rdata;
    logic [11:0] ram_addr;
    logic [1:0]  ram_en, ram_wen;
    logic [31:0] ram_wdata, ram_rdata0, ram_rdata1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] ram0 [4096];
    logic [31:0] ram1 [4096];

    icache_ctrl #(.INDEX_W(8), .OFF_W(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ready(cpu_ready),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .inv_all(inv_all), .inv_ack(inv_ack),
        .mem_rreq(mem_rreq), .mem_raddr(mem_raddr), .mem_rack(mem_rack),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .ram_addr(ram_addr), .ram_en(ram_en), .ram_wen(ram_wen),
        .ram_wdata(ram_wdata), .ram_rdata0(ram_rdata0), .ram_rdata1(ram_rdata1)
    );

    always #5 clk = ~clk;

    // Two single-port data RAMs, one-cycle read latency.
    always @(posedge clk) begin
        if (ram_en[0]) begin
            if (ram_wen[0]) ram0[ram_addr] <= ram_wdata;
            else            ram_rdata0     <= ram0[ram_addr];
        end
        if (ram_en[1]) begin
            if (ram_wen[1]) ram1[ram_addr] <= ram_wdata;
            else            ram_rdata1     <= ram1[ram_addr];
        end
    end

    // Backing-store contents: unique per word for the addresses used here.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rvalid"}, {31'd0, cpu_rvalid}, 32'd0);
        chk({tag, "_inv_ack"}, {31'd0, inv_ack}, 32'd0);
        chk({tag, "_rreq"}, {31'd0, mem_rreq}, 32'd0);
        chk({tag, "_ram_en_wen"}, {28'd0, ram_en, ram_wen}, 32'd0);
        chk({tag, "_rdata"}, cpu_rdata, 32'd0);
        chk({tag, "_raddr"}, mem_raddr, 32'd0);
    endtask

    // Miss + refill of one line. abort_beat < 16 pulls reset during that beat.
    task automatic fetch_miss(input logic [31:0] addr, input logic [1:0] way,
                              input int rack_dly, input int abort_beat);
        logic [31:0] line;
        logic [11:0] ra;
        line = {addr[31:6], 6'd0};
        @(negedge clk); cpu_req = 1'b1; cpu_addr = addr; #1;
        chk("m_accept_ready", {31'd0, cpu_ready}, 32'd1);
        @(negedge clk); cpu_req = 1'b0; #1;
        chk("m_lookup_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        chk("m_lookup_ready", {31'd0, cpu_ready}, 32'd0);
        @(negedge clk); #1;
        chk("m_rreq", {31'd0, mem_rreq}, 32'd1);
        chk("m_raddr", mem_raddr, line);
        for (int i = 0; i < rack_dly; i++) begin
            @(negedge clk); #1;
            chk("m_rreq_hold", {31'd0, mem_rreq}, 32'd1);
        end
        mem_rack = 1'b1;
        for (int b = 0; b < 16; b++) begin
            @(negedge clk);
            mem_rack   = 1'b0;
            mem_rvalid = 1'b1;
            mem_rdata  = mem_word(line + 32'(4 * b));
            if (b == abort_beat) begin
                rst = 1'b0; #1;
                chk_reset_outputs("abort");
                @(negedge clk); rst = 1'b1;
                // Late beats keep arriving and must not touch the RAMs.
                for (int k = 0; k < 3; k++) begin
                    mem_rdata = mem_word(line + 32'(4 * (b + 1 + k))); #1;
                    chk("abort_late_beat", {28'd0, ram_en, ram_wen}, 32'd0);
                    @(negedge clk);
                end
                mem_rvalid = 1'b0;
                return;
            end
            #1;
            ra = {addr[13:6], 4'(b)};
            chk("m_beat", {16'd0, ram_en, ram_wen, ram_addr}, {16'd0, way, way, ra});
            chk("m_wdata", ram_wdata, mem_word(line + 32'(4 * b)));
        end
        @(negedge clk); mem_rvalid = 1'b0; #1;
        chk("m_resp_rvalid", {31'd0, cpu_rvalid}, 32'd1);
        chk("m_resp_rdata", cpu_rdata, mem_word({addr[31:2], 2'b00}));
        chk("m_resp_ready", {31'd0, cpu_ready}, 32'd0);
        chk("m_resp_rreq", {31'd0, mem_rreq}, 32'd0);
    endtask

    // Up to three fetches accepted on consecutive cycles, all expected to hit.
    task automatic fetch_hits(input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] a2, input int n);
        logic [31:0] a [3];
        a[0] = a0; a[1] = a1; a[2] = a2;
        @(negedge clk); cpu_req = 1'b1; cpu_addr = a[0]; #1;
        chk("h_accept_ready", {31'd0, cpu_ready}, 32'd1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i + 1 < n) cpu_addr = a[i + 1];
            else           cpu_req  = 1'b0;
            #1;
            chk("h_rvalid", {31'd0, cpu_rvalid}, 32'd1);
            chk("h_rdata", cpu_rdata, mem_word(a[i]));
            chk("h_ready", {31'd0, cpu_ready}, 32'd1);
            chk("h_no_rreq", {31'd0, mem_rreq}, 32'd0);
        end
        @(negedge clk); #1;
        chk("h_idle_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; cpu_req = 1'b0; cpu_addr = '0; inv_all = 1'b0;
        mem_rack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        #2;
        chk_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Cold miss into set 0x41, way 0 (ram_addr 0x410..0x41F).
        fetch_miss(32'h0000_1040, 2'b01, 0, 16);
        // Back-to-back hits.
        fetch_hits(32'h0000_1040, 32'h0000_1044, 32'h0000_1048, 3);

        // Replacement in set 0x41: A=tag0 (way0), B=tag1 -> way1.
        fetch_miss(32'h0000_5040, 2'b10, 0, 16);
        fetch_hits(32'h0000_1040, 32'h0, 32'h0, 1);   // A touched -> way1 is LRU
        fetch_miss(32'h0000_9040, 2'b10, 0, 16);      // C replaces way 1
        fetch_miss(32'h0000_D048, 2'b01, 0, 16);      // D replaces way 0, offset 2
        fetch_hits(32'h0000_9044, 32'h0000_D07C, 32'h0000_907C, 3);

        // Invalidate wins over a same-cycle request.
        @(negedge clk); cpu_req = 1'b1; cpu_addr = 32'h0000_9044; inv_all = 1'b1; #1;
        chk("inv_ready", {31'd0, cpu_ready}, 32'd0);
        chk("inv_ack_early", {31'd0, inv_ack}, 32'd0);
        @(negedge clk); cpu_req = 1'b0; inv_all = 1'b0; #1;
        chk("inv_ack_pulse", {31'd0, inv_ack}, 32'd1);
        chk("inv_no_fetch", {31'd0, cpu_rvalid}, 32'd0);
        @(negedge clk); #1;
        chk("inv_ack_single", {31'd0, inv_ack}, 32'd0);
        fetch_miss(32'h0000_9044, 2'b01, 0, 16);      // was cached, now misses

        // Reset during beat 7 of a refill with a slow mem_rack.
        fetch_miss(32'h0000_2080, 2'b01, 5, 7);
        fetch_miss(32'h0000_2080, 2'b01, 0, 16);      // same line misses again
        fetch_hits(32'h0000_20BC, 32'h0000_2080, 32'h0, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/icache_ctrl.md
ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 Parameter INDEX_W, 8, set index width; SHALL satisfy INDEX_W + OFF_W = 12.
REQ-002 Parameter OFF_W, 4, word-offset width; line = 2^OFF_W words.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 cpu_req  in  1; cpu_addr  in  32  fetch byte address; cpu_ready  out  1  request accepted when cpu_req && cpu_ready.
REQ-006 cpu_rvalid  out  1  one-cycle data pulse; cpu_rdata  out  32  instruction word.
REQ-007 inv_all  in  1  level invalidate request; inv_ack  out  1  one-cycle completion pulse.
REQ-008 mem_rreq  out  1; mem_raddr  out  32  line-aligned; mem_rack  in  1  address accepted; mem_rvalid  in  1; mem_rdata  in  32.
REQ-009 ram_addr  out  12; ram_en  out  2; ram_wen  out  2; ram_wdata  out  32 (to both ways); ram_rdata0, ram_rdata1  in  32  1-cycle-latency way outputs.

Function
REQ-010 Address split: tag = cpu_addr[31:2+OFF_W+INDEX_W], index = next INDEX_W bits, offset = cpu_addr[2+OFF_W-1:2]; bits [1:0] ignored.
REQ-011 Storage SHALL be internal registers: per set, per way valid + tag; per set one LRU bit naming the way to replace.
REQ-012 States: IDLE, LOOKUP, MISS, REFILL, RESP.
REQ-013 IDLE: cpu_ready = !inv_all; on accept, register cpu_addr, drive ram_addr = {index, offset}, ram_en = 2'b11, ram_wen = 0, go LOOKUP.
REQ-014 IDLE with inv_all: clear every valid bit and LRU bit in one cycle, pulse inv_ack next cycle; inv_all wins over same-cycle cpu_req; inv_all ignored outside IDLE.
REQ-015 LOOKUP: hit = valid && tag match in either way; on hit assert cpu_rvalid with matching way's RAM data, set LRU[set] = other way.
REQ-016 LOOKUP hit: cpu_ready = 1; a request accepted that cycle issues its RAM read and stays in LOOKUP (one fetch per cycle back-to-back); else go IDLE.
REQ-017 Both ways matching SHALL NOT occur by construction; if forced, way 0 is selected.
REQ-018 LOOKUP miss: cpu_ready = 0; choose victim: first invalid way (way 0 first), else LRU way; register victim; go MISS.
REQ-019 MISS: mem_rreq = 1, mem_raddr = {tag, index, OFF_W+2 zero bits}, held until mem_rack; then REFILL with beat counter = 0.
REQ-020 REFILL: each mem_rvalid writes mem_rdata at ram_addr = {index, counter}, ram_en = ram_wen = one-hot victim, counter increments; beats in critical-word-first order SHALL NOT be assumed (counter order only).
REQ-021 REFILL: beat with counter == requested offset captured into response register.
REQ-022 Last beat (counter = 2^OFF_W-1): write tag, set valid for victim, LRU[set] = other way, go RESP; counter wraps to 0.
REQ-023 RESP: cpu_rvalid = 1 with captured word, cpu_ready = 0, go IDLE.
REQ-024 ram_en = 0, ram_wen = 0 in every cycle not listed above; mem_rvalid outside REFILL ignored.
REQ-025 Hit latency: 1 cycle after accept; miss latency: 3 cycles + mem_rack wait + 2^OFF_W beats.

Reset
REQ-026 On rst low, immediately: state IDLE, all valid and LRU bits 0, counter 0, cpu_rvalid 0, inv_ack 0, mem_rreq 0, ram_en 0, ram_wen 0, cpu_rdata 0, mem_raddr 0.
REQ-027 Reset mid-MISS/REFILL SHALL abandon the refill; partially written line stays invalid; late mem_rvalid beats ignored.

Verification
REQ-028 Cold miss: fetch 0x0000_1040 after reset -> mem_rreq with mem_raddr 0x0000_1040, 16 beats written to way 0 at ram_addr 0x410..0x41F, cpu_rvalid with beat 0 data in RESP.
REQ-029 Hit pipeline: fetches 0x1040, 0x1044, 0x1048 on consecutive cycles -> three cpu_rvalid on consecutive cycles, no mem_rreq.
REQ-030 Replacement: fill way 0 and way 1 of set 0x41 (tags A, B), hit A, miss tag C -> victim way 1 (ram_wen = 2'b10); then miss tag D -> victim way 0.
REQ-031 Invalidate: inv_all and cpu_req together in IDLE -> cpu_ready 0, inv_ack pulse next cycle, subsequent fetch of cached line misses.
REQ-032 Reset at beat 7 of refill -> outputs per REQ-026; later fetch of same line misses and refills fully; mem_rack delayed 5 cycles -> mem_rreq held high throughout.
